// File: rtl/afe_seq_ctl_if.sv
// afe_seq_ctl_if
//   Groups the handshake and pin signals of the AFE readout sequencer.
//   master : acquisition logic / testbench side (drives the requests, reads status and pins)
//   slave  : afe_seq_ctl side (reads the requests, drives status and AFE pins)
//   Requests : ADS_INIT_OK, SAMPLE_EN, FRAME_NUM[7:0], STOP, AFE_STO (unused input pin)
//   Status   : BUSY, FRAME_DONE, CH_VALID, CH_IDX[7:0]
//   AFE pins : AFE_CLK, AFE_INTG, AFE_TFT, AFE_IRST, AFE_SHS, AFE_SHR, AFE_STI, AFE_DF_SM,
//              AFE_PDZ, AFE_NAPZ, AFE_ENTRI, AFE_SMT_MD, AFE_INPUTZ, AFE_PGA[2:0]
interface afe_seq_ctl_if;
   logic       ADS_INIT_OK;
   logic       SAMPLE_EN;
   logic [7:0] FRAME_NUM;
   logic       STOP;
   logic       AFE_STO;
   logic       BUSY;
   logic       FRAME_DONE;
   logic       CH_VALID;
   logic [7:0] CH_IDX;
   logic       AFE_CLK;
   logic       AFE_INTG;
   logic       AFE_TFT;
   logic       AFE_IRST;
   logic       AFE_SHS;
   logic       AFE_SHR;
   logic       AFE_STI;
   logic       AFE_DF_SM;
   logic       AFE_PDZ;
   logic       AFE_NAPZ;
   logic       AFE_ENTRI;
   logic       AFE_SMT_MD;
   logic       AFE_INPUTZ;
   logic [2:0] AFE_PGA;

   modport master (
      output ADS_INIT_OK, SAMPLE_EN, FRAME_NUM, STOP, AFE_STO,
      input  BUSY, FRAME_DONE, CH_VALID, CH_IDX,
      input  AFE_CLK, AFE_INTG, AFE_TFT, AFE_IRST, AFE_SHS, AFE_SHR, AFE_STI, AFE_DF_SM,
      input  AFE_PDZ, AFE_NAPZ, AFE_ENTRI, AFE_SMT_MD, AFE_INPUTZ, AFE_PGA
   );

   modport slave (
      input  ADS_INIT_OK, SAMPLE_EN, FRAME_NUM, STOP, AFE_STO,
      output BUSY, FRAME_DONE, CH_VALID, CH_IDX,
      output AFE_CLK, AFE_INTG, AFE_TFT, AFE_IRST, AFE_SHS, AFE_SHR, AFE_STI, AFE_DF_SM,
      output AFE_PDZ, AFE_NAPZ, AFE_ENTRI, AFE_SMT_MD, AFE_INPUTZ, AFE_PGA
   );
endinterface

// File: rtl/afe_seq_ctl.sv
// afe_seq_ctl
//   Parametrised AFE readout sequencer: IRST/STI -> CLK shift-out -> SHR -> INTG/TFT -> SHS,
//   single, multi-frame or continuous, with a sticky STOP that ends after the current frame.
//   Ports: CLK_100M (system clock), CLK_RST_N (async active-low reset),
//          bus (afe_seq_ctl_if.slave: requests in, status and AFE pins out).
//   Build option: AFE_SEQ_DFSM_EN - when defined, AFE_DF_SM drops low during the TFT window;
//          otherwise AFE_DF_SM is tied high.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for a qualified SAMPLE_EN rising edge
//   IRST   | integrator reset, STI pulse at its start
//   CLK    | CH_NUM AFE_CLK periods, high half first
//   SHR    | reset-level sample pulse, then wait
//   INTG   | integration with TFT window, then INTG-low tail
//   SHS    | signal-level sample pulse, tail; FRAME_DONE on last cycle
module afe_seq_ctl #(
   parameter int CH_NUM      = 64,
   parameter int T_STI       = 5,
   parameter int T_IRST      = 10,
   parameter int T_HALF_CLK  = 65,
   parameter int T_SHR       = 5,
   parameter int T_WAIT_INTG = 100,
   parameter int T_TFT       = 1400,
   parameter int T_INTG      = 1450,
   parameter int T_WAIT_SHS  = 500,
   parameter int T_SHS       = 5,
   parameter int T_END       = 10,
   parameter int CNT_W       = 16
) (
   input logic          CLK_100M,
   input logic          CLK_RST_N,
   afe_seq_ctl_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_IRST, S_CLK, S_SHR, S_INTG, S_SHS} state_t;

   localparam logic [CNT_W-1:0] IRST_LAST = CNT_W'(T_IRST - 1);
   localparam logic [CNT_W-1:0] CLK_LAST  = CNT_W'(2 * T_HALF_CLK - 1);
   localparam logic [CNT_W-1:0] SHR_LAST  = CNT_W'(T_WAIT_INTG - 1);
   localparam logic [CNT_W-1:0] INTG_LAST = CNT_W'(T_INTG + T_WAIT_SHS - 1);
   localparam logic [CNT_W-1:0] SHS_LAST  = CNT_W'(T_SHS + T_END - 1);
   localparam logic [CNT_W-1:0] STI_LEN   = CNT_W'(T_STI);
   localparam logic [CNT_W-1:0] HALF_LEN  = CNT_W'(T_HALF_CLK);
   localparam logic [CNT_W-1:0] SHR_LEN   = CNT_W'(T_SHR);
   localparam logic [CNT_W-1:0] INTG_LEN  = CNT_W'(T_INTG);
   localparam logic [CNT_W-1:0] TFT_LEN   = CNT_W'(T_TFT);
   localparam logic [CNT_W-1:0] SHS_LEN   = CNT_W'(T_SHS);
   localparam logic [7:0]       CH_LAST   = 8'(CH_NUM - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [7:0]       ch, ch_nxt;
   logic [7:0]       frames, frames_nxt;
   logic             stop_q, stop_nxt;
   logic             sample_q;
   logic             start;

   logic busy_q, frame_done_q, ch_valid_q, clk_q, intg_q, tft_q, irst_q, shs_q, shr_q, sti_q;
   logic sto_unused;

   assign start      = (state == S_IDLE) && bus.ADS_INIT_OK && bus.SAMPLE_EN && !sample_q;
   assign sto_unused = bus.AFE_STO;

   always_ff @(posedge CLK_100M or negedge CLK_RST_N) begin
      if (!CLK_RST_N) begin
         state    <= S_IDLE;
         cnt      <= '0;
         ch       <= '0;
         frames   <= '0;
         stop_q   <= 1'b0;
         sample_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         ch       <= ch_nxt;
         frames   <= frames_nxt;
         stop_q   <= stop_nxt;
         sample_q <= bus.SAMPLE_EN;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt + CNT_W'(1);
      ch_nxt     = ch;
      frames_nxt = frames;
      stop_nxt   = stop_q;
      if (state != S_IDLE && bus.STOP) stop_nxt = 1'b1;
      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (start) begin
               state_nxt  = S_IRST;
               frames_nxt = bus.FRAME_NUM;
               stop_nxt   = 1'b0;
            end
         end
         S_IRST: if (cnt == IRST_LAST) begin
            state_nxt = S_CLK;
            cnt_nxt   = '0;
            ch_nxt    = '0;
         end
         S_CLK: if (cnt == CLK_LAST) begin
            cnt_nxt = '0;
            if (ch == CH_LAST) state_nxt = S_SHR;
            else               ch_nxt    = ch + 8'd1;
         end
         S_SHR: if (cnt == SHR_LAST) begin
            state_nxt = S_INTG;
            cnt_nxt   = '0;
         end
         S_INTG: if (cnt == INTG_LAST) begin
            state_nxt = S_SHS;
            cnt_nxt   = '0;
         end
         S_SHS: if (cnt == SHS_LAST) begin
            cnt_nxt = '0;
            if (frames != 8'd0) frames_nxt = frames - 8'd1;
            // A STOP arriving on the very last cycle still ends the acquisition here.
            if (frames == 8'd1 || stop_q || bus.STOP) begin
               state_nxt = S_IDLE;
               stop_nxt  = 1'b0;
            end else begin
               state_nxt = S_IRST;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Pins are decoded from the next state/count so the registered outputs line up
   // with the state register (start detected in cycle k -> pins high in cycle k+1).
   always_ff @(posedge CLK_100M or negedge CLK_RST_N) begin
      if (!CLK_RST_N) begin
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         ch_valid_q   <= 1'b0;
         clk_q        <= 1'b0;
         intg_q       <= 1'b0;
         tft_q        <= 1'b0;
         irst_q       <= 1'b0;
         shs_q        <= 1'b0;
         shr_q        <= 1'b0;
         sti_q        <= 1'b0;
      end else begin
         busy_q       <= state_nxt != S_IDLE;
         frame_done_q <= (state_nxt == S_SHS) && (cnt_nxt == SHS_LAST);
         ch_valid_q   <= (state_nxt == S_CLK) && (cnt_nxt == '0);
         clk_q        <= (state_nxt == S_CLK) && (cnt_nxt < HALF_LEN);
         intg_q       <= (state_nxt == S_INTG) && (cnt_nxt < INTG_LEN);
         tft_q        <= (state_nxt == S_INTG) && (cnt_nxt < TFT_LEN);
         irst_q       <= state_nxt == S_IRST;
         shs_q        <= (state_nxt == S_SHS) && (cnt_nxt < SHS_LEN);
         shr_q        <= (state_nxt == S_SHR) && (cnt_nxt < SHR_LEN);
         sti_q        <= (state_nxt == S_IRST) && (cnt_nxt < STI_LEN);
      end
   end

`ifdef AFE_SEQ_DFSM_EN
   logic df_q;
   always_ff @(posedge CLK_100M or negedge CLK_RST_N) begin
      if (!CLK_RST_N) df_q <= 1'b1;
      else            df_q <= !((state_nxt == S_INTG) && (cnt_nxt < TFT_LEN));
   end
   assign bus.AFE_DF_SM = df_q;
`else
   assign bus.AFE_DF_SM = 1'b1;
`endif

   assign bus.BUSY       = busy_q;
   assign bus.FRAME_DONE = frame_done_q;
   assign bus.CH_VALID   = ch_valid_q;
   assign bus.CH_IDX     = ch;
   assign bus.AFE_CLK    = clk_q;
   assign bus.AFE_INTG   = intg_q;
   assign bus.AFE_TFT    = tft_q;
   assign bus.AFE_IRST   = irst_q;
   assign bus.AFE_SHS    = shs_q;
   assign bus.AFE_SHR    = shr_q;
   assign bus.AFE_STI    = sti_q;
   assign bus.AFE_PDZ    = 1'b1;
   assign bus.AFE_NAPZ   = 1'b1;
   assign bus.AFE_ENTRI  = 1'b1;
   assign bus.AFE_SMT_MD = 1'b1;
   assign bus.AFE_INPUTZ = 1'b0;
   assign bus.AFE_PGA    = 3'b111;
endmodule

// File: tb/tb_afe_seq_ctl.sv
// Testbench for afe_seq_ctl: a default-parameter instance checked by event counts
// against the frame-length arithmetic, and a small-parameter instance checked cycle
// by cycle against a frame-offset model under randomized frame counts and STOP times.
module tb_afe_seq_ctl;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   afe_seq_ctl_if m ();
   afe_seq_ctl_if s ();

   afe_seq_ctl dut_m (.CLK_100M(clk), .CLK_RST_N(rst_n), .bus(m.slave));

   // Small frame: IRST 3 | CLK 4x6 | SHR 4 | INTG 5+2 | SHS 2+3  = 43 cycles
   afe_seq_ctl #(
      .CH_NUM(4), .T_STI(2), .T_IRST(3), .T_HALF_CLK(3), .T_SHR(2), .T_WAIT_INTG(4),
      .T_TFT(3), .T_INTG(5), .T_WAIT_SHS(2), .T_SHS(2), .T_END(3), .CNT_W(8)
   ) dut_s (.CLK_100M(clk), .CLK_RST_N(rst_n), .bus(s.slave));

   localparam int F_DEF = 10 + 2*65*64 + 100 + 1450 + 500 + 5 + 10;  // 10395
   localparam int F_S   = 43;
`ifdef AFE_SEQ_DFSM_EN
   localparam int DF_LOW = 1400;
`else
   localparam int DF_LOW = 0;
`endif

   int vectors = 0;
   int miscompares = 0;

   // Expected small-instance outputs t cycles after the first busy cycle, nfr frames.
   function automatic logic [18:0] small_exp(input int t, input int nfr);
      logic busy, ck, irst, sti, shr, intg, tft, shs, df, cv, fd;
      logic [7:0] idx;
      int o, c;
      {busy, ck, irst, sti, shr, intg, tft, shs, cv, fd} = '0;
      df  = 1'b1;
      idx = 8'd0;
      if (t < nfr * F_S) begin
         busy = 1'b1;
         o = t % F_S;
         if (o < 3) begin
            irst = 1'b1;
            sti  = (o < 2);
         end else if (o < 27) begin
            c  = o - 3;
            ck = (c % 6) < 3;
            cv = (c % 6) == 0;
            if (cv) idx = 8'(c / 6);
         end else if (o < 31) begin
            shr = (o - 27) < 2;
         end else if (o < 38) begin
            intg = (o - 31) < 5;
            tft  = (o - 31) < 3;
         end else begin
            shs = (o - 38) < 2;
            fd  = (o == 42);
         end
      end
`ifdef AFE_SEQ_DFSM_EN
      df = !tft;
`endif
      return {busy, ck, irst, sti, shr, intg, tft, shs, df, cv, fd, idx};
   endfunction

   // Runs one acquisition on the default instance and gathers event statistics.
   // SAMPLE_EN is re-pulsed mid-frame; that edge must be ignored while BUSY.
   task automatic run_frames(input int fnum, input int stop_fd, input int stop_cv, input int limit,
                             output logic [2:0] first, output int busy_cnt, output int cv_cnt,
                             output int fd_cnt, output int idx_err, output int fd_last,
                             output int reentry, output int clk_hi, output int df_low,
                             output int late_busy);
      int cyc = 0;
      logic prev_fd = 1'b0;
      logic stopped = 1'b0;
      {cv_cnt, fd_cnt, idx_err, reentry, clk_hi, df_low, late_busy} = '0;
      m.SAMPLE_EN   = 1'b0;
      m.FRAME_NUM   = 8'(fnum);
      m.ADS_INIT_OK = 1'b1;
      @(negedge clk);
      m.SAMPLE_EN = 1'b1;
      @(negedge clk);
      first = {m.BUSY, m.AFE_IRST, m.AFE_STI};
      while (m.BUSY && cyc < limit) begin
         cyc++;
         if (m.CH_VALID) begin
            if (m.CH_IDX !== 8'(cv_cnt % 64)) idx_err++;
            cv_cnt++;
         end
         if (m.AFE_CLK) clk_hi++;
         if (!m.AFE_DF_SM) df_low++;
         if (prev_fd && m.AFE_IRST) reentry++;
         if (m.FRAME_DONE) fd_cnt++;
         prev_fd = m.FRAME_DONE;
         if (m.STOP) m.STOP = 1'b0;
         if (stop_fd >= 0 && !stopped && fd_cnt == stop_fd && cv_cnt == stop_cv) begin
            m.STOP  = 1'b1;
            stopped = 1'b1;
         end
         if (cyc == 100) m.SAMPLE_EN = 1'b0;
         if (cyc == 200) m.SAMPLE_EN = 1'b1;
         @(negedge clk);
      end
      m.STOP   = 1'b0;
      busy_cnt = m.BUSY ? -1 : cyc;
      fd_last  = int'(prev_fd);
      repeat (20) begin
         if (m.BUSY) late_busy++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      m.ADS_INIT_OK = 1'b0; m.SAMPLE_EN = 1'b0; m.FRAME_NUM = 8'd0; m.STOP = 1'b0; m.AFE_STO = 1'b0;
      s.ADS_INIT_OK = 1'b0; s.SAMPLE_EN = 1'b0; s.FRAME_NUM = 8'd0; s.STOP = 1'b0; s.AFE_STO = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({m.BUSY, m.FRAME_DONE, m.CH_VALID} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_status: got %b expected 000", {m.BUSY, m.FRAME_DONE, m.CH_VALID});
      end
      vectors++;
      if (m.CH_IDX !== 8'd0) begin
         miscompares++;
         $display("FAIL reset_ch_idx: got %0d expected 0", m.CH_IDX);
      end
      vectors++;
      if ({m.AFE_CLK, m.AFE_INTG, m.AFE_TFT, m.AFE_IRST, m.AFE_SHS, m.AFE_SHR, m.AFE_STI, m.AFE_DF_SM}
          !== 8'b0000_0001) begin
         miscompares++;
         $display("FAIL reset_pins: got %b expected 00000001",
                  {m.AFE_CLK, m.AFE_INTG, m.AFE_TFT, m.AFE_IRST, m.AFE_SHS, m.AFE_SHR, m.AFE_STI, m.AFE_DF_SM});
      end
      vectors++;
      if ({m.AFE_PDZ, m.AFE_NAPZ, m.AFE_ENTRI, m.AFE_SMT_MD, m.AFE_INPUTZ, m.AFE_PGA} !== 8'b1111_0111) begin
         miscompares++;
         $display("FAIL tied_pins: got %b expected 11110111",
                  {m.AFE_PDZ, m.AFE_NAPZ, m.AFE_ENTRI, m.AFE_SMT_MD, m.AFE_INPUTZ, m.AFE_PGA});
      end
      vectors++;
      if ({s.BUSY, s.AFE_DF_SM} !== 2'b01) begin
         miscompares++;
         $display("FAIL reset_small: got %b expected 01", {s.BUSY, s.AFE_DF_SM});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_no_init;
      int seen = 0;
      m.ADS_INIT_OK = 1'b0;
      @(negedge clk);
      m.SAMPLE_EN = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (m.BUSY) seen++;
      end
      vectors++;
      if (seen !== 0) begin
         miscompares++;
         $display("FAIL no_init_busy: got %0d busy cycles expected 0", seen);
      end
      m.SAMPLE_EN   = 1'b0;
      m.ADS_INIT_OK = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_frame;
      logic [2:0] first;
      int b, cv, fd, ie, fl, re, ch, dl, lb;
      run_frames(1, -1, 0, 12000, first, b, cv, fd, ie, fl, re, ch, dl, lb);
      vectors++;
      if (first !== 3'b111) begin
         miscompares++;
         $display("FAIL single_start_pins: got %b expected 111", first);
      end
      vectors++;
      if (b !== F_DEF) begin
         miscompares++;
         $display("FAIL single_busy_len: got %0d expected %0d", b, F_DEF);
      end
      vectors++;
      if (cv !== 64 || ie !== 0) begin
         miscompares++;
         $display("FAIL single_ch_valid: got %0d pulses %0d bad idx expected 64 and 0", cv, ie);
      end
      vectors++;
      if (fd !== 1 || fl !== 1) begin
         miscompares++;
         $display("FAIL single_frame_done: got %0d pulses last=%0d expected 1 last=1", fd, fl);
      end
      vectors++;
      if (ch !== 64 * 65) begin
         miscompares++;
         $display("FAIL single_clk_high: got %0d expected %0d", ch, 64 * 65);
      end
      vectors++;
      if (dl !== DF_LOW) begin
         miscompares++;
         $display("FAIL single_df_sm_low: got %0d expected %0d", dl, DF_LOW);
      end
      vectors++;
      if (lb !== 0) begin
         miscompares++;
         $display("FAIL single_ignored_edge: got %0d busy cycles after frame expected 0", lb);
      end
   endtask

   task automatic test_multi_frame;
      logic [2:0] first;
      int b, cv, fd, ie, fl, re, ch, dl, lb;
      run_frames(3, -1, 0, 35000, first, b, cv, fd, ie, fl, re, ch, dl, lb);
      vectors++;
      if (b !== 3 * F_DEF) begin
         miscompares++;
         $display("FAIL multi_busy_len: got %0d expected %0d", b, 3 * F_DEF);
      end
      vectors++;
      if (fd !== 3 || fl !== 1) begin
         miscompares++;
         $display("FAIL multi_frame_done: got %0d last=%0d expected 3 last=1", fd, fl);
      end
      vectors++;
      if (re !== 2) begin
         miscompares++;
         $display("FAIL multi_irst_reentry: got %0d expected 2", re);
      end
      vectors++;
      if (cv !== 192 || ie !== 0) begin
         miscompares++;
         $display("FAIL multi_ch_valid: got %0d pulses %0d bad idx expected 192 and 0", cv, ie);
      end
   endtask

   task automatic test_continuous_stop;
      logic [2:0] first;
      int b, cv, fd, ie, fl, re, ch, dl, lb;
      run_frames(0, 1, 84, 35000, first, b, cv, fd, ie, fl, re, ch, dl, lb);
      vectors++;
      if (fd !== 2) begin
         miscompares++;
         $display("FAIL cont_stop_frames: got %0d expected 2", fd);
      end
      vectors++;
      if (b !== 2 * F_DEF) begin
         miscompares++;
         $display("FAIL cont_stop_busy_len: got %0d expected %0d", b, 2 * F_DEF);
      end
   endtask

   task automatic test_random_small;
      for (int it = 0; it < 6; it++) begin
         int fnum, maxf, r, nfr;
         logic do_stop;
         logic [18:0] obs, exp;
         fnum    = (it == 0) ? 2 : int'($urandom_range(0, 3));
         do_stop = (fnum == 0) || (it > 0 && $urandom_range(0, 1) == 1);
         maxf    = (fnum == 0) ? 3 : fnum;
         r       = -1;
         nfr     = fnum;
         if (do_stop) begin
            r = int'($urandom_range(0, maxf * F_S - 1));
            if (r % F_S == F_S - 1) r--;
            nfr = r / F_S + 1;
         end
         if (it == 0) begin
            // STOP while idle must not shorten the following acquisition
            @(negedge clk); s.STOP = 1'b1;
            @(negedge clk); s.STOP = 1'b0;
         end
         s.SAMPLE_EN   = 1'b0;
         s.FRAME_NUM   = 8'(fnum);
         s.ADS_INIT_OK = 1'b1;
         @(negedge clk);
         s.SAMPLE_EN = 1'b1;
         for (int t = 0; t < nfr * F_S + 4; t++) begin
            @(negedge clk);
            obs = {s.BUSY, s.AFE_CLK, s.AFE_IRST, s.AFE_STI, s.AFE_SHR, s.AFE_INTG, s.AFE_TFT,
                   s.AFE_SHS, s.AFE_DF_SM, s.CH_VALID, s.FRAME_DONE, s.CH_VALID ? s.CH_IDX : 8'd0};
            exp = small_exp(t, nfr);
            vectors++;
            if (obs !== exp) begin
               miscompares++;
               $display("FAIL small_seq it=%0d t=%0d: got %h expected %h", it, t, obs, exp);
            end
            s.STOP = (t == r);
            if (t == 5) s.SAMPLE_EN = 1'b0;
            if (t == 9) s.SAMPLE_EN = 1'b1;
         end
         s.STOP = 1'b0;
      end
      s.SAMPLE_EN = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_intg;
      int cyc = 0;
      int fd = 0;
      int bz = 0;
      m.SAMPLE_EN = 1'b0;
      m.FRAME_NUM = 8'd1;
      @(negedge clk);
      m.SAMPLE_EN = 1'b1;
      @(negedge clk);
      m.SAMPLE_EN = 1'b0;
      while (!m.AFE_INTG && cyc < 12000) begin
         @(negedge clk);
         cyc++;
      end
      repeat (10) @(negedge clk);
      vectors++;
      if ({m.AFE_INTG, m.BUSY} !== 2'b11) begin
         miscompares++;
         $display("FAIL intg_reached: got %b expected 11", {m.AFE_INTG, m.BUSY});
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({m.AFE_INTG, m.AFE_TFT, m.AFE_DF_SM, m.BUSY} !== 4'b0010) begin
         miscompares++;
         $display("FAIL reset_mid_intg: got %b expected 0010",
                  {m.AFE_INTG, m.AFE_TFT, m.AFE_DF_SM, m.BUSY});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3000) begin
         @(negedge clk);
         if (m.FRAME_DONE) fd++;
         if (m.BUSY) bz++;
      end
      vectors++;
      if (fd !== 0 || bz !== 0) begin
         miscompares++;
         $display("FAIL after_reset_quiet: got %0d done %0d busy expected 0 and 0", fd, bz);
      end
   endtask

   initial begin
      test_reset();
      test_no_init();
      test_single_frame();
      test_multi_frame();
      test_continuous_stop();
      test_random_small();
      test_reset_mid_intg();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/afe_seq_ctl.md
# afe_seq_ctl

Parametrised AFE readout sequencer, the successor to the fixed single-shot AFE controller. Sits between the ADS init/acquisition logic and the AFE control pins. Drives the IRST/STI → CLK shift-out → SHR → INTG/TFT → SHS frame sequence with all phase durations and the channel count set by parameters. Adds multi-frame and continuous acquisition, a STOP request, and per-channel strobes that let the ADC capture logic align samples to AFE_CLK edges.

## Interface
Parameters:
- CH_NUM, 64: AFE_CLK rising edges (channels) per frame, 1..255
- T_STI, 5: AFE_STI high time, cycles
- T_IRST, 10: IRST phase length, cycles; AFE_IRST high for the whole phase
- T_HALF_CLK, 65: AFE_CLK half period, cycles
- T_SHR, 5: AFE_SHR high time, cycles
- T_WAIT_INTG, 100: SHR phase length, cycles
- T_TFT, 1400: AFE_TFT high / AFE_DF_SM low time, cycles
- T_INTG, 1450: AFE_INTG high time, cycles
- T_WAIT_SHS, 500: INTG-low tail before SHS, cycles
- T_SHS, 5: AFE_SHS high time, cycles
- T_END, 10: SHS phase tail, cycles
- CNT_W, 16: phase counter width
- Legal values: T_STI≤T_IRST, T_SHR≤T_WAIT_INTG, T_TFT≤T_INTG, every T_* ≥1, T_INTG+T_WAIT_SHS < 2^CNT_W.

Ports:
- CLK_100M  in  1  system clock
- CLK_RST_N  in  1  reset, asynchronous, active-low
- ADS_INIT_OK  in  1  start qualifier
- SAMPLE_EN  in  1  rising edge requests an acquisition
- FRAME_NUM  in  8  frames per acquisition, latched at start; 0 = continuous
- STOP  in  1  request end after the current frame; sticky until IDLE
- BUSY  out  1  high whenever state ≠ IDLE
- FRAME_DONE  out  1  one-cycle pulse at end of each SHS phase
- CH_VALID  out  1  one-cycle pulse coincident with each AFE_CLK rising edge
- CH_IDX  out  8  channel index for CH_VALID, 0..CH_NUM-1
- AFE_CLK, AFE_INTG, AFE_TFT, AFE_IRST, AFE_SHS, AFE_SHR, AFE_STI, AFE_DF_SM  out  1  registered control pins
- AFE_PDZ, AFE_NAPZ, AFE_ENTRI, AFE_SMT_MD  out  1  tied 1
- AFE_INPUTZ  out  1  tied 0
- AFE_PGA  out  3  tied 3'b111
- AFE_STO  in  1  unused; kept for pin compatibility

## Operation
- States: IDLE, IRST, CLK, SHR, INTG, SHS.
- IDLE→IRST when ADS_INIT_OK=1, SAMPLE_EN=1 and registered SAMPLE_EN=0. On that transition FRAME_NUM is latched into the frame counter and the STOP latch is cleared.
- IRST: AFE_IRST=1 for T_IRST cycles; AFE_STI=1 for the first T_STI cycles. Then → CLK.
- CLK: CH_NUM periods, each T_HALF_CLK high then T_HALF_CLK low, starting high. CH_VALID is pulsed with CH_IDX=n on the rising edge of period n. After the last low half → SHR.
- SHR: AFE_SHR=1 for the first T_SHR cycles; phase length T_WAIT_INTG. Then → INTG.
- INTG: AFE_INTG=1 for T_INTG cycles; AFE_TFT=1 and AFE_DF_SM=0 for T_TFT cycles; phase length T_INTG+T_WAIT_SHS. Then → SHS.
- SHS: AFE_SHS=1 for T_SHS cycles; phase length T_SHS+T_END. FRAME_DONE pulses on the last cycle.
- After SHS: the latched count is decremented when non-zero. Go to IDLE if the count reaches 0 (finite mode) or STOP is latched. Otherwise go to IRST with no idle gap.
- STOP is latched in any non-IDLE state and never truncates a frame. STOP in IDLE is ignored.
- SAMPLE_EN edges while BUSY are ignored.
- All phase counters are CNT_W bits, count from 0 and reset on every phase change.

## Timing
- Start edge detected in cycle k → BUSY, AFE_IRST and AFE_STI all high in cycle k+1. All pin outputs are registered.
- Frame length: T_IRST + 2·T_HALF_CLK·CH_NUM + T_WAIT_INTG + T_INTG + T_WAIT_SHS + T_SHS + T_END cycles.
- Default frame: 10+8320+100+1950+15 = 10395 cycles.
- Reset values (async, any state): all controls 0 except AFE_DF_SM=1. BUSY, FRAME_DONE, CH_VALID = 0; CH_IDX=0; state IDLE; latches cleared.
- Reset asserted mid-frame drops the outputs immediately. No frame completes after release.

## Configuration
- AFE_SEQ_DFSM_EN defined: AFE_DF_SM is driven low during the TFT window, as above.
- Not defined: AFE_DF_SM is tied 1 and no compensation dump is ever issued. AFE_TFT timing is unchanged.

## Test plan
- Defaults, FRAME_NUM=1, one SAMPLE_EN edge → 64 CH_VALID pulses with CH_IDX 0..63, one FRAME_DONE, BUSY high for exactly 10395 cycles.
- FRAME_NUM=3 → 3 FRAME_DONE pulses, IRST re-entered the cycle after each SHS, BUSY high 31185 cycles.
- FRAME_NUM=0, STOP pulsed mid-CLK of frame 2 → frame 2 completes, then IDLE; exactly 2 FRAME_DONE pulses.
- ADS_INIT_OK=0 with SAMPLE_EN edge → stays IDLE. A second SAMPLE_EN edge while BUSY → ignored.
- CLK_RST_N low during INTG → AFE_INTG=0, AFE_DF_SM=1, BUSY=0 in the same cycle; no FRAME_DONE after release.
- CH_NUM=4, T_HALF_CLK=3, AFE_SEQ_DFSM_EN undefined → AFE_CLK period 6 cycles with 4 rising edges; AFE_DF_SM constantly 1.
